// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter for the fetch and data paths; data has priority, bounded by a fetch starvation limit
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic [1:0]  owner
);
  typedef enum logic [1:0] {IDLE = 2'b00, IBUS = 2'b01, DBUS = 2'b10} state_t;
  state_t state, next;
  logic [3:0] starve_cnt, starve_nxt;
  logic dreq, idle, ibus, dbus, starved, grant_d, grant_i;
  always_ff @(posedge CLK)
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= next;
      starve_cnt <= starve_nxt;
    end
  always_comb begin
    dreq       = dREN | dWEN;
    idle       = state == IDLE;
    ibus       = state == IBUS;
    dbus       = state == DBUS;
    starved    = iREN & (starve_cnt >= 4'(STARVE_LIMIT));
    grant_d    = idle & dreq & ~starved;
    grant_i    = idle & ~grant_d & iREN;
    next       = grant_d ? DBUS : grant_i ? IBUS :
                 (ibus & iREN & ~ramready) ? IBUS :
                 (dbus & dreq & ~ramready) ? DBUS : IDLE;
    starve_nxt = (grant_d & iREN) ? starve_cnt + 4'd1 : (grant_d | grant_i) ? 4'd0 : starve_cnt;
    ramREN     = (ibus & iREN) | (dbus & dREN & ~dWEN);
    ramWEN     = dbus & dWEN;
    ramaddr    = ibus ? iaddr : dbus ? daddr : '0;
    ramstore   = dbus ? dstore : '0;
    iwait      = iREN & ~(ibus & ramready);
    dwait      = dreq & ~(dbus & ramready);
    iload      = (ibus & iREN & ramready) ? ramload : '0;
    dload      = (dbus & dreq & ramready) ? ramload : '0;
    owner      = state;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and sequence checks of the memory arbiter
module tb_mem_arbiter;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ramready = 1'b0;
  logic [31:0] iaddr = 32'h40, daddr = '0, dstore = 32'hDEADBEEF, ramload = '0;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [1:0]  owner;
  int checks = 0, errors = 0;

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .owner(owner)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  in;
    logic [31:0] da, rl;
    logic [1:0]  st;
    logic [31:0] ra, rs;
    logic [1:0]  w;
    logic [31:0] il, dl;
    logic [1:0]  own;
  } vec_t;

  vec_t v[14];
  logic [1:0] exp_g[6];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic chk_vec(input int i, input vec_t e);
    chk($sformatf("v%0d strobes", i), 32'({ramREN, ramWEN}), 32'(e.st));
    chk($sformatf("v%0d ramaddr", i), ramaddr, e.ra);
    chk($sformatf("v%0d ramstore", i), ramstore, e.rs);
    chk($sformatf("v%0d waits", i), 32'({iwait, dwait}), 32'(e.w));
    chk($sformatf("v%0d iload", i), iload, e.il);
    chk($sformatf("v%0d dload", i), dload, e.dl);
    chk($sformatf("v%0d owner", i), 32'(owner), 32'(e.own));
  endtask

  initial begin
    // in = {rst, iREN, dREN, dWEN, ramready}; st = {ramREN, ramWEN}; w = {iwait, dwait}
    v[0]  = '{5'b11000, '0, '0, 2'b00, '0, '0, 2'b10, '0, '0, 2'd0};
    v[1]  = '{5'b01000, '0, '0, 2'b00, '0, '0, 2'b10, '0, '0, 2'd0};
    v[2]  = '{5'b01000, '0, '0, 2'b10, 32'h40, '0, 2'b10, '0, '0, 2'd1};
    v[3]  = '{5'b01000, '0, '0, 2'b10, 32'h40, '0, 2'b10, '0, '0, 2'd1};
    v[4]  = '{5'b01001, '0, 32'h8C220004, 2'b10, 32'h40, '0, 2'b00, 32'h8C220004, '0, 2'd1};
    v[5]  = '{5'b00000, '0, '0, 2'b00, '0, '0, 2'b00, '0, '0, 2'd0};
    v[6]  = '{5'b01100, 32'h100, '0, 2'b00, '0, '0, 2'b11, '0, '0, 2'd0};
    v[7]  = '{5'b01101, 32'h100, 32'h11112222, 2'b10, 32'h100, 32'hDEADBEEF, 2'b10, '0, 32'h11112222, 2'd2};
    v[8]  = '{5'b01000, 32'h100, '0, 2'b00, '0, '0, 2'b10, '0, '0, 2'd0};
    v[9]  = '{5'b01001, '0, 32'h33, 2'b10, 32'h40, '0, 2'b00, 32'h33, '0, 2'd1};
    v[10] = '{5'b00110, 32'h200, '0, 2'b00, '0, '0, 2'b01, '0, '0, 2'd0};
    v[11] = '{5'b00110, 32'h200, '0, 2'b01, 32'h200, 32'hDEADBEEF, 2'b01, '0, '0, 2'd2};
    v[12] = '{5'b00111, 32'h200, 32'h55, 2'b01, 32'h200, 32'hDEADBEEF, 2'b00, '0, 32'h55, 2'd2};
    v[13] = '{5'b00001, '0, 32'h77, 2'b00, '0, '0, 2'b00, '0, '0, 2'd0};
    exp_g = '{2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1};
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 14; i++) begin
      {RST, iREN, dREN, dWEN, ramready} = v[i].in;
      daddr = v[i].da;
      ramload = v[i].rl;
      @(negedge CLK);
      chk_vec(i, v[i]);
      @(posedge CLK);
      #1;
    end
    // starvation: fetch held, data continuous, always-ready RAM
    RST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; ramready = 1'b1; daddr = 32'h100; ramload = 32'h9;
    for (int g = 0; g < 6; g++) begin
      @(negedge CLK);
      chk($sformatf("starve idle %0d", g), 32'(owner), 32'd0);
      @(negedge CLK);
      chk($sformatf("starve grant %0d", g), 32'(owner), 32'(exp_g[g]));
    end
    @(posedge CLK);
    #1;
    // withdrawal mid-IBUS
    dREN = 1'b0; ramready = 1'b0;
    @(posedge CLK);
    #1;
    chk("wd owner ibus", 32'(owner), 32'd1);
    chk("wd ramREN on", 32'(ramREN), 32'd1);
    iREN = 1'b0; ramready = 1'b1; ramload = 32'hBAD0BAD0;
    #1;
    chk("wd ramREN drop", 32'(ramREN), 32'd0);
    chk("wd iload drop", iload, 32'd0);
    chk("wd iwait drop", 32'(iwait), 32'd0);
    @(posedge CLK);
    #1;
    chk("wd owner idle", 32'(owner), 32'd0);
    chk("wd strobes idle", 32'({ramREN, ramWEN}), 32'd0);
    chk("wd late iload", iload, 32'd0);
    // reset mid-DBUS
    ramready = 1'b0; dREN = 1'b1; daddr = 32'h300;
    @(posedge CLK);
    #1;
    chk("rst owner dbus", 32'(owner), 32'd2);
    chk("rst ramREN on", 32'(ramREN), 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0; ramready = 1'b1;
    #1;
    chk("rst owner idle", 32'(owner), 32'd0);
    chk("rst strobes off", 32'({ramREN, ramWEN}), 32'd0);
    chk("rst late dload", dload, 32'd0);
    chk("rst dwait held", 32'(dwait), 32'd1);
    chk("rst ramaddr", ramaddr, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
